// File: rtl/serdes_shift_ctrl.sv
// Serial/parallel shift engine: IDLE/LOAD/SHIFT/DONE controller with its own shift register.
// Supports PISO and SIPO frames, MSB- or LSB-first, with back-to-back frames from DONE.
module serdes_shift_ctrl #(
  parameter int   WIDTH          = 8,
  parameter logic IDLE_SER_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_select,
  input  logic             msb_first,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic             load,
  output logic             shift,
  output logic             ser_out,
  output logic             ser_valid,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             mode_q;
  logic             msbf_q;
  logic             last_bit;
  logic             accept;
  logic             fill_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
  // PISO shifts zeros in behind the data; SIPO shifts the serial input in.
  assign fill_bit = mode_q ? ser_in : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_SHIFT;
      S_SHIFT: if (last_bit) state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_LOAD : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      shreg   <= '0;
      par_out <= '0;
      mode_q  <= 1'b0;
      msbf_q  <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= mode_select;
        msbf_q <= msb_first;
      end
      case (state)
        S_LOAD: begin
          shreg <= mode_q ? '0 : par_in;
          cnt   <= '0;
        end
        S_SHIFT: begin
          cnt   <= last_bit ? '0 : cnt + CW'(1);
          shreg <= msbf_q ? {shreg[WIDTH-2:0], fill_bit} : {fill_bit, shreg[WIDTH-1:1]};
        end
        S_DONE: begin
          if (mode_q) par_out <= shreg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    load      = 1'b0;
    shift     = 1'b0;
    ser_valid = 1'b0;
    par_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ser_out   = IDLE_SER_LEVEL;
    case (state)
      S_LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      S_SHIFT: begin
        shift     = 1'b1;
        busy      = 1'b1;
        ser_valid = ~mode_q;
        if (!mode_q) ser_out = msbf_q ? shreg[WIDTH-1] : shreg[0];
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        par_valid = mode_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serdes_shift_ctrl.sv
// Bench for serdes_shift_ctrl: an 8-bit and a 5-bit instance checked every cycle against a
// frame-position model, plus literal expectations for the directed frames.
module tb_serdes_shift_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start8 = 0, mode8 = 0, msbf8 = 0, sin8 = 0;
  logic [7:0] par8 = '0;
  logic       load8, shift8, ser_out8, ser_valid8, par_valid8, busy8, done8;
  logic [7:0] par_out8;

  logic       start5 = 0, mode5 = 0, msbf5 = 0, sin5 = 0;
  logic [4:0] par5 = '0;
  logic       load5, shift5, ser_out5, ser_valid5, par_valid5, busy5, done5;
  logic [4:0] par_out5;

  serdes_shift_ctrl #(.WIDTH(8), .IDLE_SER_LEVEL(1'b0)) d8 (
    .clk(clk), .rst(rst), .start(start8), .mode_select(mode8), .msb_first(msbf8),
    .par_in(par8), .ser_in(sin8), .load(load8), .shift(shift8), .ser_out(ser_out8),
    .ser_valid(ser_valid8), .par_out(par_out8), .par_valid(par_valid8), .busy(busy8),
    .done(done8)
  );

  serdes_shift_ctrl #(.WIDTH(5), .IDLE_SER_LEVEL(1'b0)) d5 (
    .clk(clk), .rst(rst), .start(start5), .mode_select(mode5), .msb_first(msbf5),
    .par_in(par5), .ser_in(sin5), .load(load5), .shift(shift5), .ser_out(ser_out5),
    .ser_valid(ser_valid5), .par_out(par_out5), .par_valid(par_valid5), .busy(busy5),
    .done(done5)
  );

  int errors = 0;
  int checks = 0;

  // Model: pos = -1 idle, 0 load, 1..W shift cycle pos-1, W+1 done.
  int         pos   [2];
  logic [7:0] data  [2];
  logic [7:0] rx    [2];
  logic [7:0] par   [2];
  logic       mode  [2];
  logic       msbf  [2];

  task automatic mstep(input int k, input int w, input logic st, input logic m,
                       input logic f, input logic [7:0] p, input logic si);
    if (pos[k] < 0) begin
      if (st) begin pos[k] = 0; mode[k] = m; msbf[k] = f; end
    end else if (pos[k] == 0) begin
      data[k] = p; rx[k] = '0; pos[k] = 1;
    end else if (pos[k] <= w) begin
      if (mode[k]) rx[k][msbf[k] ? w - pos[k] : pos[k] - 1] = si;
      pos[k] = pos[k] + 1;
    end else begin
      if (mode[k]) par[k] = rx[k];
      if (st) begin pos[k] = 0; mode[k] = m; msbf[k] = f; end
      else pos[k] = -1;
    end
  endtask

  function automatic logic [14:0] mexp(input int k, input int w);
    logic ld, sh, so, sv, pv, bz, dn;
    ld = (pos[k] == 0);
    sh = (pos[k] >= 1) && (pos[k] <= w);
    sv = sh && !mode[k];
    so = 1'b0;
    if (sv) so = data[k][msbf[k] ? w - pos[k] : pos[k] - 1];
    pv = (pos[k] == w + 1) && mode[k];
    bz = (pos[k] >= 0);
    dn = (pos[k] == w + 1);
    return {ld, sh, so, sv, pv, bz, dn, par[k]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        pos[k] = -1; data[k] = '0; rx[k] = '0; par[k] = '0; mode[k] = 0; msbf[k] = 0;
      end
    end else begin
      mstep(0, 8, start8, mode8, msbf8, par8, sin8);
      mstep(1, 5, start5, mode5, msbf5, {3'b000, par5}, sin5);
    end
  end

  always @(negedge clk) begin
    logic [14:0] a8, a5, e8, e5;
    a8 = {load8, shift8, ser_out8, ser_valid8, par_valid8, busy8, done8, par_out8};
    a5 = {load5, shift5, ser_out5, ser_valid5, par_valid5, busy5, done5, 3'b000, par_out5};
    e8 = mexp(0, 8);
    e5 = mexp(1, 5);
    checks++;
    if (a8 !== e8) begin
      errors++;
      $display("FAIL cycle_w8 t=%0t got=%h expected=%h", $time, a8, e8);
    end
    checks++;
    if (a5 !== e5) begin
      errors++;
      $display("FAIL cycle_w5 t=%0t got=%h expected=%h", $time, a5, e5);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic frame8(input logic m, input logic f, input logic [7:0] p, input logic [7:0] s,
                        output logic [7:0] bits, output int nbusy, output int nload,
                        output int ndone, output int npv, output int done_at);
    bits = '0; nbusy = 0; nload = 0; ndone = 0; npv = 0; done_at = -1;
    @(negedge clk);
    start8 = 1; mode8 = m; msbf8 = f; par8 = p;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin start8 = 0; mode8 = ~m; msbf8 = ~f; end
      if (busy8) nbusy++;
      if (load8) nload++;
      if (par_valid8) npv++;
      if (done8) begin ndone++; if (done_at < 0) done_at = c; end
      if (ser_valid8) bits = {bits[6:0], ser_out8};
      if (c >= 2 && c <= 9) sin8 = s[9-c];
    end
  endtask

  initial begin
    logic [7:0]  bits;
    logic [15:0] bits16;
    logic [4:0]  bits5;
    int nbusy, nload, ndone, npv, done_at, nshift;

    repeat (2) @(negedge clk);
    chk("reset_busy", busy8, 0);
    chk("reset_par_out", par_out8, 0);
    chk("reset_ser_out", ser_out8, 0);
    rst = 0;
    @(negedge clk);

    frame8(0, 1, 8'hC1, 8'h00, bits, nbusy, nload, ndone, npv, done_at);
    chk("piso_msb_bits", bits, 8'hC1);
    chk("piso_msb_done_at", done_at, 10);
    chk("piso_msb_ndone", ndone, 1);

    frame8(0, 0, 8'hC1, 8'h00, bits, nbusy, nload, ndone, npv, done_at);
    chk("piso_lsb_bits", bits, 8'h83);
    chk("piso_lsb_nload", nload, 1);
    chk("piso_lsb_nbusy", nbusy, 10);
    chk("piso_par_out_untouched", par_out8, 0);

    frame8(1, 1, 8'h00, 8'hC1, bits, nbusy, nload, ndone, npv, done_at);
    chk("sipo_msb_par_out", par_out8, 8'hC1);
    chk("sipo_msb_npv", npv, 1);
    frame8(1, 0, 8'h00, 8'hC1, bits, nbusy, nload, ndone, npv, done_at);
    chk("sipo_lsb_par_out", par_out8, 8'h83);

    // Three frames with start held high; mode flipped during each DONE.
    bits16 = '0; nbusy = 0; nload = 0; ndone = 0; npv = 0;
    @(negedge clk);
    start8 = 1; mode8 = 0; msbf8 = 1; par8 = 8'hA5; sin8 = 0;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      if (busy8) nbusy++;
      if (load8) nload++;
      if (done8) ndone++;
      if (par_valid8) npv++;
      if (ser_valid8) bits16 = {bits16[14:0], ser_out8};
      if (c == 10) mode8 = 1;
      if (c >= 12 && c <= 19) sin8 = 8'hA6 >> (19 - c);
      if (c == 20) begin mode8 = 0; par8 = 8'h3C; end
      if (c == 30) start8 = 0;
    end
    chk("b2b_ser_bits", bits16, 16'hA53C);
    chk("b2b_nload", nload, 3);
    chk("b2b_ndone", ndone, 3);
    chk("b2b_npv", npv, 1);
    chk("b2b_nbusy", nbusy, 30);
    chk("b2b_par_out", par_out8, 8'hA6);

    // Start pulse and mode change mid-frame must not disturb the PISO frame.
    bits = '0; nbusy = 0; nload = 0;
    @(negedge clk);
    start8 = 1; mode8 = 0; msbf8 = 1; par8 = 8'h5A;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 0;
      if (c == 5) begin start8 = 1; mode8 = 1; end
      if (c == 6) start8 = 0;
      if (busy8) nbusy++;
      if (load8) nload++;
      if (ser_valid8) bits = {bits[6:0], ser_out8};
    end
    chk("ignore_start_nload", nload, 1);
    chk("ignore_start_nbusy", nbusy, 10);
    chk("ignore_start_bits", bits, 8'h5A);
    chk("ignore_start_par_out", par_out8, 8'hA6);

    // Asynchronous reset in the middle of a SIPO frame.
    @(negedge clk);
    start8 = 1; mode8 = 1; msbf8 = 1; sin8 = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) start8 = 0;
    end
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", busy8, 0);
    chk("async_rst_par_out", par_out8, 0);
    chk("async_rst_ser_out", ser_out8, 0);
    @(negedge clk);
    rst = 0;
    ndone = 0; npv = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (done8) ndone++;
      if (par_valid8) npv++;
    end
    chk("after_rst_ndone", ndone, 0);
    chk("after_rst_npv", npv, 0);
    chk("after_rst_par_out", par_out8, 0);

    // Five-bit instance, non power-of-two counter wrap.
    bits5 = '0; nshift = 0; nbusy = 0;
    @(negedge clk);
    start5 = 1; mode5 = 0; msbf5 = 1; par5 = 5'b10110;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start5 = 0;
      if (busy5) nbusy++;
      if (shift5) nshift++;
      if (ser_valid5) bits5 = {bits5[3:0], ser_out5};
    end
    chk("w5_bits", bits5, 5'b10110);
    chk("w5_nshift", nshift, 5);
    chk("w5_nbusy", nbusy, 7);
    chk("w5_cnt_wrap", d5.cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
